// File: rtl/tetris_grid_pkg.sv
// Shared playfield constants and the line_clear state encoding.
// Used by line_clear, grid_addr, grid_mem and the display scanner.
package tetris_grid_pkg;

  localparam int unsigned COLS = 10;
  localparam int unsigned ROWS = 20;
  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 8;

  localparam logic [DW-1:0] EMPTY_CELL = '0;

  typedef enum logic [2:0] {
    LC_IDLE,
    LC_SCAN,
    LC_SCAN_END,
    LC_COPY_RD,
    LC_COPY_WR,
    LC_CLR_TOP,
    LC_DONE
  } lc_state_t;

endpackage

// File: rtl/grid_addr.sv
// Row/column to linear cell address: addr = row*COLS + col.
// Ports: row, col in; addr_c out (combinational).
module grid_addr
  import tetris_grid_pkg::*;
#(
  parameter int unsigned COLS = tetris_grid_pkg::COLS,
  parameter int unsigned ROWS = tetris_grid_pkg::ROWS,
  parameter int unsigned AW   = tetris_grid_pkg::AW
) (
  input  logic [$clog2(ROWS)-1:0] row,
  input  logic [$clog2(COLS)-1:0] col,
  output logic [AW-1:0]           addr_c
);

  assign addr_c = AW'(32'(row) * 32'(COLS) + 32'(col));

endmodule

// File: rtl/line_clear.sv
// Line-clear engine: scans the grid bottom-up through memory port A, shifts
// everything above each full row down by one, clears the top row and reports
// the number of rows removed.
// Ports: clk, rst (sync, active-high), start, busy, done, lines,
//        mem_addr/mem_wdata/mem_we/mem_rdata (grid_mem port A).
module line_clear
  import tetris_grid_pkg::*;
#(
  parameter int unsigned COLS = tetris_grid_pkg::COLS,
  parameter int unsigned ROWS = tetris_grid_pkg::ROWS,
  parameter int unsigned AW   = tetris_grid_pkg::AW,
  parameter int unsigned DW   = tetris_grid_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [4:0]    lines,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);

  lc_state_t     state;
  logic [RW-1:0] r;       // row under scan
  logic [RW-1:0] rr;      // destination row of the copy loop
  logic [CW-1:0] col;
  logic          full;    // AND of non-empty over the reads seen so far
  logic          copy_wr; // this cycle writes back the word just read
  logic [RW-1:0] a_row;   // registered row/col of the port-A address
  logic [CW-1:0] a_col;

  logic cell_full_c;
  logic row_full_c;
  logic last_col_c;

  assign cell_full_c = (mem_rdata != DW'(EMPTY_CELL));
  assign row_full_c  = full & cell_full_c;
  assign last_col_c  = (col == CW'(COLS - 1));

  // Address comes straight from registered row/col, so it is glitch-free
  // and valid for the whole cycle the state issues it.
  grid_addr #(
    .COLS (COLS),
    .ROWS (ROWS),
    .AW   (AW)
  ) u_grid_addr (
    .row    (a_row),
    .col    (a_col),
    .addr_c (mem_addr)
  );

  // Copy data is only known in the write cycle itself (1-cycle read latency),
  // so write data is forwarded from the read port under a registered select.
  assign mem_wdata = copy_wr ? mem_rdata : DW'(EMPTY_CELL);

  // Main FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LC_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      lines   <= '0;
      mem_we  <= 1'b0;
      copy_wr <= 1'b0;
      r       <= '0;
      rr      <= '0;
      col     <= '0;
      full    <= 1'b0;
      a_row   <= '0;
      a_col   <= '0;
    end else begin
      unique case (state)
        LC_IDLE: begin
          if (start) begin
            state <= LC_SCAN;
            busy  <= 1'b1;
            lines <= '0;
            r     <= RW'(ROWS - 1);
            col   <= '0;
            full  <= 1'b1;
            a_row <= RW'(ROWS - 1);
            a_col <= '0;
          end
        end

        LC_SCAN: begin
          // Data for col-1 is on the read port; col 0's slot holds stale data.
          if (col != '0) full <= row_full_c;
          if (last_col_c) begin
            state <= LC_SCAN_END;
          end else begin
            col   <= col + CW'(1);
            a_col <= col + CW'(1);
          end
        end

        LC_SCAN_END: begin
          col   <= '0;
          a_col <= '0;
          if (!row_full_c) begin
            if (r != '0) begin
              state <= LC_SCAN;
              r     <= r - RW'(1);
              a_row <= r - RW'(1);
              full  <= 1'b1;
            end else begin
              state <= LC_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            if (lines != '1) lines <= lines + 5'd1;
            rr <= r;
            if (r != '0) begin
              state <= LC_COPY_RD;
              a_row <= r - RW'(1);
            end else begin
              state  <= LC_CLR_TOP;
              a_row  <= '0;
              mem_we <= 1'b1;
            end
          end
        end

        LC_COPY_RD: begin
          state   <= LC_COPY_WR;
          a_row   <= rr;
          a_col   <= col;
          mem_we  <= 1'b1;
          copy_wr <= 1'b1;
        end

        LC_COPY_WR: begin
          copy_wr <= 1'b0;
          if (last_col_c) begin
            col   <= '0;
            a_col <= '0;
            if (rr == RW'(1)) begin
              state  <= LC_CLR_TOP;
              a_row  <= '0;
            end else begin
              state  <= LC_COPY_RD;
              mem_we <= 1'b0;
              rr     <= rr - RW'(1);
              a_row  <= rr - RW'(2);
            end
          end else begin
            state  <= LC_COPY_RD;
            mem_we <= 1'b0;
            col    <= col + CW'(1);
            a_row  <= rr - RW'(1);
            a_col  <= col + CW'(1);
          end
        end

        LC_CLR_TOP: begin
          if (last_col_c) begin
            // Rescan the same row: the row above has just moved into it.
            state  <= LC_SCAN;
            mem_we <= 1'b0;
            col    <= '0;
            full   <= 1'b1;
            a_row  <= r;
            a_col  <= '0;
          end else begin
            col   <= col + CW'(1);
            a_col <= col + CW'(1);
          end
        end

        LC_DONE: begin
          state <= LC_IDLE;
          done  <= 1'b0;
        end

        default: begin
          state <= LC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear.sv
// Scoreboard bench for line_clear driving a behavioural grid_mem model.
module tb_line_clear;
  import tetris_grid_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [4:0]    lines;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  line_clear #(
    .COLS (COLS),
    .ROWS (ROWS),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .lines     (lines),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // grid_mem port A model plus a bench-only load port (used while idle).
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_wdata;

  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (bd_we) mem[bd_addr]  <= bd_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    int lines;
    int busy;
    int wr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks    = 0;
  int   errors    = 0;
  int   done_seen = 0;
  int   busy_cnt  = 0;
  int   wr_cnt    = 0;
  int   exp_g [0:ROWS*COLS-1];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation on every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
      wr_cnt   = 0;
      sb.delete();
    end else begin
      if (busy)   busy_cnt++;
      if (mem_we) wr_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("lines", int'(lines), mon_e.lines);
          check("busy_cycles", busy_cnt, mon_e.busy);
          check("write_count", wr_cnt, mon_e.wr);
        end
        busy_cnt = 0;
        wr_cnt   = 0;
        done_seen++;
      end
    end
  end

  task automatic clear_grid();
    @(posedge clk); #1;
    bd_we = 1'b1;
    for (int i = 0; i < (1 << AW); i++) begin
      bd_addr  = AW'(i);
      bd_wdata = '0;
      @(posedge clk); #1;
    end
    bd_we = 1'b0;
    for (int i = 0; i < ROWS*COLS; i++) exp_g[i] = 0;
  endtask

  task automatic set_cell(input int row, input int c, input int v);
    @(posedge clk); #1;
    bd_we    = 1'b1;
    bd_addr  = AW'(row*COLS + c);
    bd_wdata = DW'(v);
    @(posedge clk); #1;
    bd_we    = 1'b0;
  endtask

  task automatic set_row(input int row, input int v);
    for (int c = 0; c < COLS; c++) set_cell(row, c, v);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic check_grid(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < ROWS*COLS; i++)
      if (int'(mem[i]) !== exp_g[i]) bad++;
    check(name, bad, 0);
  endtask

  task automatic run_pass(input int el, input int eb, input int ew, input int repulse);
    exp_t e;
    int   seen;
    e.lines = el;
    e.busy  = eb;
    e.wr    = ew;
    seen    = done_seen;
    sb.push_back(e);
    pulse_start();
    if (repulse > 0) begin
      repeat (repulse) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int i = 0; i < 3000 && done_seen == seen; i++) @(negedge clk);
    check("done_count", done_seen - seen, 1);
    repeat (5) @(negedge clk);
    check("lines_held", int'(lines), el);
    check("idle_busy", int'(busy), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    bd_we    = 1'b0;
    bd_addr  = '0;
    bd_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_lines", int'(lines), 0);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_wdata", int'(mem_wdata), 0);
    rst = 1'b0;

    // Empty grid: 20 row scans of 11 cycles.
    clear_grid();
    run_pass(0, 220, 0, 0);
    check_grid("grid_empty");

    // Bottom row full: scan + 390 shift + rescan + 19 scans.
    clear_grid();
    set_row(19, 5);
    run_pass(1, 621, 200, 0);
    check_grid("grid_row19");

    // Rows 19 and 17 full, row 18 holds one cell.
    clear_grid();
    set_row(19, 7);
    set_row(17, 9);
    set_cell(18, 4, 3);
    run_pass(2, 1002, 390, 0);
    exp_g[19*COLS + 4] = 3;
    check_grid("grid_rows19_17");
    check("cell_19_4", int'(mem[19*COLS + 4]), 3);

    // Top row full: only the 10 top-row clears, then a rescan of row 0.
    clear_grid();
    set_row(0, 2);
    run_pass(1, 241, 10, 0);
    check_grid("grid_row0");

    // start re-pulsed mid-copy is ignored.
    clear_grid();
    set_row(19, 5);
    run_pass(1, 621, 200, 50);
    check_grid("grid_repulse");

    // Reset in the middle of the copy loop.
    clear_grid();
    set_row(19, 5);
    pulse_start();
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("mid_busy", int'(busy), 1);
    check("mid_lines", int'(lines), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_mem_we", int'(mem_we), 0);
    check("rst_mid_lines", int'(lines), 0);
    check("rst_mid_done", int'(done), 0);
    rst = 1'b0;

    clear_grid();
    run_pass(0, 220, 0, 0);
    check_grid("grid_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
